// File: rtl/leg_mem_pkg.sv
// Shared types and helpers for the byte-wide BRAM load/store initiator.
package leg_mem_pkg;

    // Access size encoding as presented on the request port.
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2,
        RSVD = 2'd3
    } mem_size_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESP   = 2'd3
    } bwm_state_e;

    // Number of BRAM bytes touched by one request of the given size.
    function automatic logic [2:0] size_bytes(input mem_size_e size);
        logic [2:0] n;
        case (size)
            BYTE:    n = 3'd1;
            HALF:    n = 3'd2;
            WORD:    n = 3'd4;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

    // Natural alignment check on the two low address bits.
    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            HALF:    bad = addr_lo[0];
            WORD:    bad = |addr_lo;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Zero- or sign-extend the assembled little-endian load bytes to 32 bits.
    function automatic logic [31:0] extend_load(input logic [31:0] bytes_in,
                                                input mem_size_e   size,
                                                input logic        sgn);
        logic [31:0] r;
        case (size)
            BYTE:    r = sgn ? {{24{bytes_in[7]}},  bytes_in[7:0]}  : {24'd0, bytes_in[7:0]};
            HALF:    r = sgn ? {{16{bytes_in[15]}}, bytes_in[15:0]} : {16'd0, bytes_in[15:0]};
            WORD:    r = bytes_in;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Select byte idx (little-endian) of a 32-bit word.
    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    // Replace byte idx (little-endian) of a 32-bit word.
    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            2'd3:    r[31:24] = b;
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bram.sv
// Byte-wide single-port BRAM: synchronous write, registered read-before-write.
module bram #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

    // Write the addressed byte when enabled and register the old contents for readout.
    always_ff @(posedge i_clk) begin
        if (i_write) begin
            mem_q[i_addr] <= i_data;
        end
        o_data <= mem_q[i_addr];
    end

endmodule

// File: rtl/bram_word_master.sv
// Load/store initiator that splits byte/half/word requests into little-endian
// byte accesses on a single-port BRAM and returns one response per request.
module bram_word_master
    import leg_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_signed,
    input  logic [31:0]           i_req_addr,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [31:0]           o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_mem_write,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    input  logic [DATA_WIDTH-1:0] i_mem_data
);

    if (DATA_WIDTH != 8) begin : g_dw_check
        $error("bram_word_master: DATA_WIDTH must be 8");
    end

    bwm_state_e            state_q, state_d;
    logic [1:0]            k_q, k_d;
    logic                  write_q, write_d;
    mem_size_e             size_q, size_d;
    logic                  signed_q, signed_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           lbuf_q, lbuf_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;

    mem_size_e             req_size_s;
    logic                  range_err_s;
    logic                  req_err_s;
    logic                  accept_s;
    logic [2:0]            nbytes_s;
    logic [2:0]            last_idx3_s;
    logic                  last_s;
    logic [1:0]            k_next_s;
    logic [1:0]            cap_idx_s;
    logic [31:0]           lbuf_cap_s;

    // Request decode: any address bit at or above ADDR_WIDTH is out of range,
    // which is also why base+k can never wrap inside the BRAM.
    assign req_size_s  = mem_size_e'(i_req_size);
    assign range_err_s = ((i_req_addr >> ADDR_WIDTH) != 32'd0);
    assign req_err_s   = (req_size_s == RSVD) | is_misaligned(req_size_s, i_req_addr[1:0]) | range_err_s;
    assign accept_s    = i_req_valid & req_ready_q & (state_q == ST_IDLE);

    assign nbytes_s    = size_bytes(size_q);
    assign last_idx3_s = nbytes_s - 3'd1;
    assign last_s      = (k_q == last_idx3_s[1:0]);
    assign k_next_s    = k_q + 2'd1;

    // Read data arrives one cycle after its address, so the byte landing now
    // belongs to k-1 in ACCESS and to the final byte in DRAIN.
    always_comb begin
        if (state_q == ST_DRAIN) begin
            cap_idx_s = last_idx3_s[1:0];
        end else begin
            cap_idx_s = k_q - 2'd1;
        end
        lbuf_cap_s = put_byte(lbuf_q, cap_idx_s, i_mem_data[7:0]);
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = req_err_s ? ST_RESP : ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (last_s) begin
                    state_d = write_q ? ST_RESP : ST_DRAIN;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_DRAIN: state_d = ST_RESP;
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the datapath and of every registered output.
    always_comb begin
        k_d         = k_q;
        write_d     = write_q;
        size_d      = size_q;
        signed_d    = signed_q;
        wdata_d     = wdata_q;
        base_d      = base_q;
        lbuf_d      = lbuf_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    write_d     = i_req_write;
                    size_d      = req_size_s;
                    signed_d    = i_req_signed;
                    wdata_d     = i_req_wdata;
                    base_d      = i_req_addr[ADDR_WIDTH-1:0];
                    k_d         = 2'd0;
                    lbuf_d      = 32'd0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = req_err_s;
                    if (req_err_s) begin
                        mem_write_d = 1'b0;
                    end else begin
                        mem_write_d = i_req_write;
                        mem_addr_d  = i_req_addr[ADDR_WIDTH-1:0];
                        mem_data_d  = i_req_write ? i_req_wdata[7:0] : 8'd0;
                    end
                end else begin
                    mem_write_d = 1'b0;
                end
            end
            ST_ACCESS: begin
                k_d = k_next_s;
                if (!write_q && (k_q != 2'd0)) begin
                    lbuf_d = lbuf_cap_s;
                end else begin
                    lbuf_d = lbuf_q;
                end
                if (last_s) begin
                    mem_write_d = 1'b0;
                    mem_data_d  = 8'd0;
                end else begin
                    mem_write_d = write_q;
                    mem_addr_d  = base_q + {{(ADDR_WIDTH-2){1'b0}}, k_next_s};
                    mem_data_d  = write_q ? get_byte(wdata_q, k_next_s) : 8'd0;
                end
            end
            ST_DRAIN: begin
                lbuf_d      = lbuf_cap_s;
                rsp_rdata_d = extend_load(lbuf_cap_s, size_q, signed_q);
                mem_write_d = 1'b0;
            end
            ST_RESP:  mem_write_d = 1'b0;
            default:  mem_write_d = 1'b0;
        endcase
    end

    // Datapath and output registers; async reset clears everything, which
    // also drops an in-flight BRAM write immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            k_q         <= 2'd0;
            write_q     <= 1'b0;
            size_q      <= BYTE;
            signed_q    <= 1'b0;
            wdata_q     <= 32'd0;
            base_q      <= '0;
            lbuf_q      <= 32'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
        end else begin
            k_q         <= k_d;
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            wdata_q     <= wdata_d;
            base_q      <= base_d;
            lbuf_q      <= lbuf_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_mem_write = mem_write_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_data  = mem_data_q;

endmodule

// File: tb/tb_bram_word_master.sv
// Bench for bram_word_master wired back-to-back with a byte BRAM.
module tb_bram_word_master;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic          req_signed = 1'b0;
    logic [31:0]   req_addr = 32'd0;
    logic [31:0]   req_wdata = 32'd0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mw_cnt = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          mw;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    bram_word_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_write(req_write), .i_req_size(req_size), .i_req_signed(req_signed),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_mem_write(mem_write), .o_mem_addr(mem_addr),
        .o_mem_data(mem_wdata), .i_mem_data(mem_rdata)
    );

    bram #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) u_bram (
        .i_clk(clk), .i_write(mem_write), .i_addr(mem_addr),
        .i_data(mem_wdata), .o_data(mem_rdata)
    );

    // Edge counter and count of edges on which the BRAM performs a write.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) mw_cnt <= mw_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rd, input logic err, input int lat);
        vec_t v;
        v.wr = wr; v.sz = sz; v.sg = sg; v.addr = addr; v.wd = wd;
        v.exp_rd = rd; v.exp_err = err; v.exp_lat = lat;
        return v;
    endfunction

    // Issue one request at a negedge, score its response; optionally hold
    // i_rsp_ready low for 'hold' cycles while a bogus request is offered.
    task automatic do_req(input vec_t v, input int hold);
        exp_t e;
        int   acc;
        int   mw0;
        int   n;
        bit   got;
        n = (v.sz == 2'd0) ? 1 : (v.sz == 2'd1) ? 2 : 4;
        e.rd = v.exp_rd; e.err = v.exp_err; e.lat = v.exp_lat;
        e.mw = (v.wr && !v.exp_err) ? n : 0;
        sb_q.push_back(e);
        req_valid = 1'b1; req_write = v.wr; req_size = v.sz; req_signed = v.sg;
        req_addr = v.addr; req_wdata = v.wd;
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (req_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("req_ready_timeout", 64'(got), 64'd1);
        acc = cyc + 1;
        mw0 = mw_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (rsp_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("rsp_valid_timeout", 64'(got), 64'd1);
        e = sb_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rd));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        check("rsp_latency", 64'(cyc - acc), 64'(e.lat));
        check("mem_write_edges", 64'(mw_cnt - mw0), 64'(e.mw));
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
            req_addr = 32'h0000_0044; req_wdata = 32'h5555_5555;
            @(negedge clk);
            check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            check("hold_rsp_rdata", 64'(rsp_rdata), 64'(e.rd));
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("rsp_valid_cleared", 64'(rsp_valid), 64'd0);
        check("ready_after_rsp", 64'(req_ready), 64'd1);
    endtask

    initial begin
        // Reset behaviour
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs",
              {8'd0, req_ready, rsp_valid, rsp_rdata, rsp_err, mem_write, mem_addr, mem_wdata},
              64'd0);
        rst_n = 1'b1;
        #1;
        check("ready_low_at_release", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("ready_first_edge", 64'(req_ready), 64'd1);

        // Table-driven vectors
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0, 4));
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 5));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h010, 32'h0,        32'h000000EF, 1'b0, 2));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h011, 32'h0,        32'h000000BE, 1'b0, 2));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h012, 32'h0,        32'h000000AD, 1'b0, 2));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h013, 32'h0,        32'h000000DE, 1'b0, 2));
        vecs.push_back(mk(1'b0, 2'd1, 1'b1, 32'h012, 32'h0,        32'hFFFFDEAD, 1'b0, 3));
        vecs.push_back(mk(1'b0, 2'd1, 1'b0, 32'h010, 32'h0,        32'h0000BEEF, 1'b0, 3));
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, 32'h005, 32'h12345680, 32'h0,        1'b0, 1));
        vecs.push_back(mk(1'b0, 2'd0, 1'b1, 32'h005, 32'h0,        32'hFFFFFF80, 1'b0, 2));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h005, 32'h0,        32'h00000080, 1'b0, 2));
        vecs.push_back(mk(1'b1, 2'd1, 1'b0, 32'h007, 32'h1234,     32'h0,        1'b1, 0));
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,       32'h0,        1'b1, 0));
        vecs.push_back(mk(1'b0, 2'd3, 1'b0, 32'h000, 32'h0,        32'h0,        1'b1, 0));
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h012, 32'h0,        32'h0,        1'b1, 0));
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h80000010, 32'h0,   32'h0,        1'b1, 0));
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, 32'hFFC, 32'hCAFEF00D, 32'h0,        1'b0, 4));
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0,        32'hCAFEF00D, 1'b0, 5));
        vecs.push_back(mk(1'b0, 2'd1, 1'b1, 32'hFFE, 32'h0,        32'hFFFFCAFE, 1'b0, 3));
        foreach (vecs[i]) do_req(vecs[i], 0);

        // Backpressure: response held for 5 cycles, bogus request offered meanwhile
        do_req(mk(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0, 5), 5);
        // The bogus store must not have landed at 0x044
        do_req(mk(1'b0, 2'd2, 1'b0, 32'h044, 32'h0, 32'h0, 1'b0, 5), 0);

        // Reset in the middle of a word store
        do_req(mk(1'b1, 2'd2, 1'b0, 32'h020, 32'h11223344, 32'h0, 1'b0, 4), 0);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h020; req_wdata = 32'hAABBCCDD;
        check("mid_reset_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_k0_bus", {31'd0, mem_write, 12'(mem_addr), 8'd0, mem_wdata},
              {31'd0, 1'b1, 12'h020, 8'd0, 8'hDD});
        @(negedge clk);
        check("mid_k1_bus", {31'd0, mem_write, 12'(mem_addr), 8'd0, mem_wdata},
              {31'd0, 1'b1, 12'h021, 8'd0, 8'hCC});
        rst_n = 1'b0;
        #1;
        check("mid_reset_write_drop", 64'(mem_write), 64'd0);
        check("mid_reset_outputs",
              {8'd0, req_ready, rsp_valid, rsp_rdata, rsp_err, mem_write, mem_addr, mem_wdata},
              64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_release_ready_low", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("mid_release_ready", 64'(req_ready), 64'd1);
        do_req(mk(1'b0, 2'd2, 1'b0, 32'h020, 32'h0, 32'h112233DD, 1'b0, 5), 0);

        // Half-word sweep
        for (int i = 0; i < 32; i++)
            do_req(mk(1'b1, 2'd1, 1'b0, 32'(2 * i), 32'(i + 1), 32'h0, 1'b0, 2), 0);
        for (int i = 0; i < 32; i++)
            do_req(mk(1'b0, 2'd1, 1'b0, 32'(2 * i), 32'h0, 32'(i + 1), 1'b0, 3), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_word_master.md
Name: bram_word_master

Overview:
Initiator for the byte-wide single-port BRAM (`bram`, synchronous write, 1-cycle registered read).
- Accepts byte/half/word load-store requests from the core over a valid/ready handshake.
- Sequences them into little-endian byte accesses on the BRAM port.
- Returns one response per request with read data (zero- or sign-extended) and an error flag.

Parameters:
ADDR_WIDTH, 12, BRAM address width; bytes 0 .. 2^ADDR_WIDTH-1 are reachable.
DATA_WIDTH, 8, BRAM word width; fixed at 8, elaboration error otherwise.

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_req_valid  in  1  request valid.
o_req_ready  out  1  high only in IDLE; request accepted on an edge with valid&ready.
i_req_write  in  1  1=store, 0=load.
i_req_size  in  2  0=byte, 1=half, 2=word, 3=reserved.
i_req_signed  in  1  loads only: sign-extend to 32 bits.
i_req_addr  in  32  byte address.
i_req_wdata  in  32  store data; low 8/16/32 bits used.
o_rsp_valid  out  1  response valid; held until i_rsp_ready.
i_rsp_ready  in  1  response consumed on an edge with valid&ready.
o_rsp_rdata  out  32  load data; 0 for stores and errors.
o_rsp_err  out  1  misaligned, out-of-range or reserved-size request.
o_mem_write  out  1  to bram i_write.
o_mem_addr  out  ADDR_WIDTH  to bram i_addr.
o_mem_data  out  DATA_WIDTH  to bram i_data.
i_mem_data  in  DATA_WIDTH  from bram o_data.

Behaviour:
- Reset (async, any state): state=IDLE, all registers 0.
  - Outputs 0: o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_mem_write, o_mem_addr, o_mem_data.
  - o_mem_write must drop asynchronously, so a write in flight is aborted.
  - o_req_ready rises on the first edge after i_rst_n deasserts.
- N (bytes) = 1/2/4 for size 0/1/2.
- Error condition, evaluated at accept:
  - size==3,
  - half with addr[0]!=0,
  - word with addr[1:0]!=0,
  - any addr bit at or above ADDR_WIDTH set.
- States: IDLE, ACCESS, DRAIN, RESP.
- IDLE: ready=1.
  - On accept, latch write, size, signed, wdata, base=addr[ADDR_WIDTH-1:0]; set k=0.
  - If error: go to RESP with err=1, rdata=0; no BRAM access.
  - Otherwise go to ACCESS.
- ACCESS: o_mem_addr=base+k; k increments each edge.
  - Store: o_mem_write=1, o_mem_data=wdata byte k (little-endian).
  - Load: o_mem_write=0; at each edge with k>=1, capture i_mem_data into byte k-1.
  - At the edge with k==N-1: store goes to RESP, load goes to DRAIN.
- DRAIN: o_mem_write=0, o_mem_addr holds last address.
  - Capture i_mem_data into byte N-1.
  - Build rdata: zero-extend, or sign-extend from bit 8N-1 if signed.
  - Go to RESP.
- RESP: o_rsp_valid=1; rdata and err stable.
  - On the edge with i_rsp_ready: clear valid, go to IDLE. The next request may be accepted on the following edge, not the same one.
- Latency (edges from the accept edge to o_rsp_valid rising):
  - error: 0, i.e. rises on the accept edge itself;
  - store: N;
  - load: N+1.
- o_mem_write is never high outside ACCESS. Addresses never wrap, because out-of-range requests are rejected at accept.
- Request inputs are ignored outside IDLE.

Decomposition:
- Package leg_mem_pkg:
  - mem_size_e (BYTE, HALF, WORD, RSVD);
  - bwm_state_e;
  - functions size_bytes(size), is_misaligned(size, addr), extend_load(bytes, size, signed).
- Single module; no sub-module.
- Testbench instantiates bram_word_master + bram (ADDR_WIDTH 12) back-to-back.

Test Plan:
1. Word store 0xDEADBEEF @0x010, then word load @0x010
   -> BRAM bytes 0x010..0x013 = EF,BE,AD,DE;
   -> store rsp at accept+4, load rsp at accept+5;
   -> rdata=0xDEADBEEF, err=0.
2. Byte store 0x80 @0x005; load byte signed -> 0xFFFFFF80; load byte unsigned -> 0x00000080; latency 2 each.
3. Half store 0x1234 @0x007 (misaligned)
   -> err=1, rdata=0, o_mem_write never asserted;
   -> also word load @0x1000 (out of range) -> err=1; size=3 -> err=1.
4. Backpressure: hold i_rsp_ready=0 for 5 cycles after a load
   -> o_rsp_valid, rdata held stable; o_req_ready=0 throughout;
   -> accepted request proceeds only after release.
5. Reset mid-store: assert i_rst_n=0 during ACCESS k=1 of word store 0xAABBCCDD @0x020
   -> o_mem_write drops immediately;
   -> only byte 0x020=DD written (0x021..0x023 unchanged);
   -> all outputs 0; ready rises one edge after release.
6. Loop: 32 half stores value i+1 at addr 2i, then 32 half loads
   -> each returns i+1, err=0, no cross-halfword corruption.
